mp_add_seq: RTL and testbench

- Multi-precision add/subtract sequencer that time-shares one external 16-bit combinational ripple adder.
- Wide operands are processed one word per clock, least-significant word first, with the carry chained through a register between words.
- It sits between a wide-operand requester (start/done handshake) and the shared 16-bit adder datapath, which it drives through the adder-side ports.

---
 rtl/mp_add_seq.sv | 101 ++++++++++
 tb/tb_mp_add_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer driving one shared W-bit adder.
// Operands are consumed least-significant word first, one word per clock.
module mp_add_seq #(
    parameter int W     = 16,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_sub,
    input  logic [W*WORDS-1:0]   a,
    input  logic [W*WORDS-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic [W*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 ovf,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    output logic                 add_ci,
    input  logic [W-1:0]         add_s,
    input  logic                 add_co
);
    localparam int N  = W * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_d;
    logic            carry_q;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [N-1:0]    sum_q;
    logic            cout_q;
    logic            ovf_q;
    logic            last;
    logic            ovf_d;

    assign last  = (idx_q == IW'(WORDS - 1));
    assign idx_d = last ? '0 : idx_q + 1'b1;
    // Sign of the top word of the result decides overflow on the final word.
    assign ovf_d = (a_q[N-1] == b_q[N-1]) && (add_s[W-1] != a_q[N-1]);

    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_ci = 1'b0;
        if (state_q == RUN) begin
            add_a  = a_q[idx_q*W +: W];
            add_b  = b_q[idx_q*W +: W];
            add_ci = carry_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= op_sub ? ~b : b;
                        carry_q <= op_sub;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q*W +: W] <= add_s;
                    carry_q <= add_co;
                    idx_q   <= idx_d;
                    if (last) begin
                        cout_q  <= add_co;
                        ovf_q   <= ovf_d;
                        state_q <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq with a behavioural 16-bit adder attached.
module tb_mp_add_seq;
    localparam int W     = 16;
    localparam int WORDS = 4;
    localparam int N     = W * WORDS;

    typedef struct packed {
        logic [N-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy, done, cout, ovf;
    logic [N-1:0] sum;
    logic [W-1:0] add_a, add_b, add_s;
    logic         add_ci, add_co;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    mp_add_seq #(.W(W), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub),
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum),
        .cout(cout), .ovf(ovf), .add_a(add_a), .add_b(add_b),
        .add_ci(add_ci), .add_s(add_s), .add_co(add_co)
    );

    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                   input logic s);
        exp_t e;
        logic [N:0] r;
        if (s) begin
            r   = {1'b0, x} - {1'b0, y};
            e.c = (x >= y);
            e.s = r[N-1:0];
            e.v = (x[N-1] != y[N-1]) && (e.s[N-1] != x[N-1]);
        end else begin
            r   = {1'b0, x} + {1'b0, y};
            e.c = r[N];
            e.s = r[N-1:0];
            e.v = (x[N-1] == y[N-1]) && (e.s[N-1] != x[N-1]);
        end
        return e;
    endfunction

    // Caller must be #1 after a posedge with the DUT idle; returns #1 after edge k.
    task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
        a = x;
        b = y;
        op_sub = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~x;
        b = ~y;
        op_sub = ~s;
    endtask

    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = busy ? 1 : 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy === 1'b1) bcnt++;
        end
    endtask

    task automatic test_reset;
        #12;
        tests++;
        if ({busy, done, sum, cout, ovf, add_a, add_b, add_ci} !== '0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b ovf=%b add_a=%h add_b=%h ci=%b, want all 0",
                     busy, done, sum, cout, ovf, add_a, add_b, add_ci);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed;
        logic [N-1:0] ta[5], tb_[5], ts[5];
        logic         tsub[5], tc[5], tv[5];
        int           cyc, bcnt;
        exp_t         e;
        ta[0] = 64'h0000_0000_0000_FFFF; tb_[0] = 64'h1; tsub[0] = 0;
        ts[0] = 64'h0000_0000_0001_0000; tc[0] = 0; tv[0] = 0;
        ta[1] = 64'hFFFF_FFFF_FFFF_FFFF; tb_[1] = 64'h1; tsub[1] = 0;
        ts[1] = 64'h0;                   tc[1] = 1; tv[1] = 0;
        ta[2] = 64'h5;                   tb_[2] = 64'h7; tsub[2] = 1;
        ts[2] = 64'hFFFF_FFFF_FFFF_FFFE; tc[2] = 0; tv[2] = 0;
        ta[3] = 64'h7;                   tb_[3] = 64'h5; tsub[3] = 1;
        ts[3] = 64'h2;                   tc[3] = 1; tv[3] = 0;
        ta[4] = 64'h7FFF_FFFF_FFFF_FFFF; tb_[4] = 64'h1; tsub[4] = 0;
        ts[4] = 64'h8000_0000_0000_0000; tc[4] = 0; tv[4] = 1;
        for (int i = 0; i < 5; i++) begin
            q.push_back('{s: ts[i], c: tc[i], v: tv[i]});
            issue(ta[i], tb_[i], tsub[i]);
            wait_done(cyc, bcnt);
            tests++;
            if (cyc != WORDS || bcnt != WORDS + 1) begin
                fails++;
                $display("FAIL latency[%0d]: done after %0d edges busy %0d cycles, want %0d and %0d",
                         i, cyc, bcnt, WORDS, WORDS + 1);
            end
            e = q.pop_front();
            tests++;
            if ({sum, cout, ovf} !== {e.s, e.c, e.v}) begin
                fails++;
                $display("FAIL directed[%0d]: sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         i, sum, cout, ovf, e.s, e.c, e.v);
            end
            @(posedge clk);
            #1;
            tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL done_pulse[%0d]: done=%b busy=%b, want 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_carry_chain;
        int cyc, bcnt;
        exp_t e;
        q.push_back('{s: 64'h0, c: 1'b1, v: 1'b0});
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        tests++;
        if ({add_a, add_b, add_ci} !== {16'hFFFF, 16'h0001, 1'b0}) begin
            fails++;
            $display("FAIL run1_add: a=%h b=%h ci=%b, want ffff 0001 0", add_a, add_b, add_ci);
        end
        for (int i = 2; i <= 4; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (add_ci !== 1'b1) begin
                fails++;
                $display("FAIL run%0d_ci: add_ci=%b, want 1", i, add_ci);
            end
        end
        wait_done(cyc, bcnt);
        e = q.pop_front();
        tests++;
        if ({sum, cout, ovf} !== {e.s, e.c, e.v}) begin
            fails++;
            $display("FAIL chain_result: sum=%h cout=%b ovf=%b, want %h %b %b",
                     sum, cout, ovf, e.s, e.c, e.v);
        end
        @(posedge clk);
        #1;
        q.push_back(model(64'h5, 64'h7, 1'b1));
        issue(64'h5, 64'h7, 1'b1);
        tests++;
        if ({add_a, add_b, add_ci} !== {16'h0005, 16'hFFF8, 1'b1}) begin
            fails++;
            $display("FAIL run1_sub: a=%h b=%h ci=%b, want 0005 fff8 1", add_a, add_b, add_ci);
        end
        wait_done(cyc, bcnt);
        e = q.pop_front();
        tests++;
        if ({sum, cout} !== {e.s, e.c}) begin
            fails++;
            $display("FAIL sub_result: sum=%h cout=%b, want %h %b", sum, cout, e.s, e.c);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int   seen[$];
        exp_t e;
        q.push_back('{s: 64'h3, c: 1'b0, v: 1'b0});
        q.push_back('{s: 64'h3, c: 1'b0, v: 1'b0});
        a = 64'h1;
        b = 64'h2;
        op_sub = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) begin a = 64'h9; b = 64'h9; end
            if (i == 5) begin a = 64'h1; b = 64'h2; end
            if (i == 12) start = 1'b0;
            if (done === 1'b1) begin
                seen.push_back(i);
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL held_extra: unexpected done at cycle %0d, want none", i);
                end else begin
                    e = q.pop_front();
                    if (sum !== e.s) begin
                        fails++;
                        $display("FAIL held_sum: sum=%h, want %h", sum, e.s);
                    end
                end
            end
        end
        tests++;
        if (seen.size() != 2 || seen[0] != WORDS + 1 || seen[1] != 2 * WORDS + 3) begin
            fails++;
            $display("FAIL held_timing: %0d done pulses first=%0d second=%0d, want 2 at %0d and %0d",
                     seen.size(), seen.size() > 0 ? seen[0] : -1,
                     seen.size() > 1 ? seen[1] : -1, WORDS + 1, 2 * WORDS + 3);
        end
        q.delete();
    endtask

    task automatic test_abort;
        int   cyc, bcnt, nd;
        exp_t e;
        issue(64'h1, 64'h1, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            fails++;
            $display("FAIL abort: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        tests++;
        if (nd != 0) begin
            fails++;
            $display("FAIL abort_quiet: %0d cycles busy/done after abort, want 0", nd);
        end
        q.push_back(model(64'h10, 64'h20, 1'b0));
        issue(64'h10, 64'h20, 1'b0);
        wait_done(cyc, bcnt);
        e = q.pop_front();
        tests++;
        if (done !== 1'b1 || sum !== e.s) begin
            fails++;
            $display("FAIL post_abort: done=%b sum=%h, want 1 %h", done, sum, e.s);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        logic [N-1:0] x, y;
        logic         s;
        int           cyc, bcnt, bad;
        exp_t         e;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            s = 1'($urandom_range(0, 1));
            if (i % 7 == 0) y[47:0] = ~x[47:0];
            if (i % 11 == 0) y = x;
            q.push_back(model(x, y, s));
            issue(x, y, s);
            wait_done(cyc, bcnt);
            e = q.pop_front();
            tests++;
            if (cyc != WORDS || {sum, cout, ovf} !== {e.s, e.c, e.v}) begin
                fails++;
                if (bad < 10)
                    $display("FAIL random[%0d]: a=%h b=%h sub=%b sum=%h c=%b v=%b lat=%0d, want %h %b %b lat=%0d",
                             i, x, y, s, sum, cout, ovf, cyc, e.s, e.c, e.v, WORDS);
                bad++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_carry_chain();
        test_back_to_back();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
